// File: rtl/uart_tx_bus_slave.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Registers (word addresses relative to BASE_ADDR):
//   +0 TXD    (W: push byte, R: 0)
//   +4 STATUS (R: overflow, done, empty, full, busy; W1C: done[3], overflow[4])
//   +8 CTRL   (R/W: irq_en in bit 0)
// ReadData is combinational and zero whenever this slave is not selected.
module uart_tx_bus_slave #(
    parameter logic [31:0] BASE_ADDR    = 32'h40000018,
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        UART_TX,
    output logic        tx_irq
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [29:0] TXD_WA    = BASE_ADDR[31:2];
    localparam logic [29:0] STATUS_WA = TXD_WA + 30'd1;
    localparam logic [29:0] CTRL_WA   = TXD_WA + 30'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Transmit FSM and datapath state
    logic [1:0]        state,    state_d;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_d;
    logic [2:0]        bit_idx,  bit_idx_d;
    logic [7:0]        shift,    shift_d;
    logic              tx_q,     tx_d;
    logic              pop;
    logic              frame_done;

    // FIFO state
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             overflow_set;

    // Control / status registers
    logic done_flag;
    logic overflow;
    logic irq_en;

    // Bus decode
    logic sel_txd;
    logic sel_status;
    logic sel_ctrl;
    logic wr_txd;
    logic wr_status;
    logic wr_ctrl;
    logic busy;
    logic baud_end;

    // Address bits and data bits that no register uses
    logic unused_bits;

    assign unused_bits = ^{Addr[1:0], WriteData[31:8]};

    assign sel_txd    = (Addr[31:2] == TXD_WA);
    assign sel_status = (Addr[31:2] == STATUS_WA);
    assign sel_ctrl   = (Addr[31:2] == CTRL_WA);
    assign wr_txd     = MemWr && sel_txd;
    assign wr_status  = MemWr && sel_status;
    assign wr_ctrl    = MemWr && sel_ctrl;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
    assign busy       = (state != ST_IDLE);
    assign baud_end   = (baud_cnt == BAUD_LAST);

    // A push on a full FIFO is still accepted when a pop happens on the same edge
    assign push         = wr_txd && (!fifo_full || pop);
    assign overflow_set = wr_txd && fifo_full && !pop;

    assign UART_TX = tx_q;
    assign tx_irq  = done_flag & irq_en;

    // Next-state, pop and serial-line logic for the frame sequencer
    always_comb begin
        state_d    = state;
        baud_cnt_d = baud_cnt;
        bit_idx_d  = bit_idx;
        shift_d    = shift;
        pop        = 1'b0;
        frame_done = 1'b0;
        tx_d       = 1'b1;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d    = ST_START;
                    pop        = 1'b1;
                    shift_d    = fifo_mem[rd_ptr];
                    baud_cnt_d = '0;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    state_d    = ST_DATA;
                    bit_idx_d  = 3'd0;
                    baud_cnt_d = '0;
                end else begin
                    baud_cnt_d = baud_cnt + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        shift_d   = {1'b0, shift[7:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    frame_done = 1'b1;
                    baud_cnt_d = '0;
                    if (!fifo_empty) begin
                        state_d = ST_START;
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = '0;
            end
        endcase

        // Line level is derived from the next state so UART_TX stays a clean flop output
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Frame sequencer registers; reset aborts any frame and idles the line
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_cnt_d;
            bit_idx  <= bit_idx_d;
            shift    <= shift_d;
            tx_q     <= tx_d;
        end
    end

    // FIFO storage; contents need no reset because the count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= WriteData[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Sticky status flags (hardware set beats software clear) and CTRL
    always_ff @(posedge clk) begin
        if (reset) begin
            done_flag <= 1'b0;
            overflow  <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            if (frame_done) begin
                done_flag <= 1'b1;
            end else if (wr_status && WriteData[3]) begin
                done_flag <= 1'b0;
            end

            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (wr_status && WriteData[4]) begin
                overflow <= 1'b0;
            end

            if (wr_ctrl) begin
                irq_en <= WriteData[0];
            end
        end
    end

    // Zero-latency read mux; idle value 0 so it can be ORed with other slaves
    always_comb begin
        ReadData = 32'd0;
        if (MemRd) begin
            if (sel_status) begin
                ReadData = {27'd0, overflow, done_flag, fifo_empty, fifo_full, busy};
            end else if (sel_ctrl) begin
                ReadData = {31'd0, irq_en};
            end
        end
    end

endmodule
